// File: rtl/param_mode_engine_if.sv
// Bus bundle for param_mode_engine: command/operand inputs and registered results.
// The master drives commands and the slave (the engine) returns status and data.
interface param_mode_engine_if #(
  parameter int XW = 8,
  parameter int SW = 3
) ();
  logic [XW-1:0] x;
  logic [1:0]    on;
  logic          start;
  logic [XW-1:0] y;
  logic [SW-1:0] s;
  logic          b;
  logic [1:0]    regime;
  logic          active;
  logic          done;

  modport master (
    output x, on, start,
    input  y, s, b, regime, active, done
  );

  modport slave (
    input  x, on, start,
    output y, s, b, regime, active, done
  );
endinterface

// File: rtl/param_mode_engine.sv
// Mode engine: ENUM sweeps s through a full cycle, COUNT steps s down with a carry into y,
// and UPDATE loads y from x and then subtracts s from it UPD_STEPS times.
module param_mode_engine #(
  parameter int XW        = 8,
  parameter int SW        = 3,
  parameter int UPD_STEPS = 1
) (
  input logic            clk,
  input logic            rst,
  param_mode_engine_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_ENUM_ARM = 3'd1,
    ST_ENUM_RUN = 3'd2,
    ST_COUNT    = 3'd3,
    ST_UPD_LOAD = 3'd4,
    ST_UPD_SUB  = 3'd5
  } state_t;

  localparam logic [SW-1:0] S_MAX   = {SW{1'b1}};
  localparam logic [7:0]    UPD_CNT = 8'(UPD_STEPS);

  state_t        state_r, next_s;
  logic [XW-1:0] y_r, y_nxt_s;
  logic [SW-1:0] s_r, s_nxt_s;
  logic [7:0]    cnt_r, cnt_nxt_s;
  logic          b_r, b_nxt_s;
  logic [1:0]    regime_r;
  logic          done_r;

  function automatic logic [1:0] regime_of(input state_t st);
    logic [1:0] r;
    case (st)
      ST_ENUM_ARM, ST_ENUM_RUN: r = 2'd1;
      ST_COUNT:                 r = 2'd2;
      ST_UPD_LOAD, ST_UPD_SUB:  r = 2'd3;
      default:                  r = 2'd0;
    endcase
    return r;
  endfunction

  // Next-state and next-data decode; b is a pulse so it defaults low every edge.
  always_comb begin
    next_s    = state_r;
    y_nxt_s   = y_r;
    s_nxt_s   = s_r;
    cnt_nxt_s = cnt_r;
    b_nxt_s   = 1'b0;
    case (state_r)
      ST_OFF: begin
        case (bus.on)
          2'd1:    next_s = ST_ENUM_ARM;
          2'd2:    next_s = ST_COUNT;
          2'd3:    next_s = ST_UPD_LOAD;
          default: next_s = ST_OFF;
        endcase
      end
      ST_ENUM_ARM: begin
        if (bus.start) begin
          s_nxt_s = {SW{1'b0}};
          next_s  = ST_ENUM_RUN;
        end else begin
          next_s  = ST_ENUM_ARM;
        end
      end
      ST_ENUM_RUN: begin
        s_nxt_s = s_r + {{(SW-1){1'b0}}, 1'b1};
        if (s_r == S_MAX) begin
          y_nxt_s = y_r + {{(XW-1){1'b0}}, 1'b1};
          b_nxt_s = 1'b1;
          next_s  = ST_OFF;
        end else begin
          next_s  = ST_ENUM_RUN;
        end
      end
      ST_COUNT: begin
        if (!bus.start) begin
          next_s = ST_OFF;
        end else begin
          s_nxt_s = s_r - {{(SW-1){1'b0}}, 1'b1};
          // Borrow out of s carries into y.
          if (s_r == {SW{1'b0}}) begin
            y_nxt_s = y_r + {{(XW-1){1'b0}}, 1'b1};
            b_nxt_s = 1'b1;
          end else begin
            b_nxt_s = 1'b0;
          end
        end
      end
      ST_UPD_LOAD: begin
        y_nxt_s   = bus.x;
        cnt_nxt_s = UPD_CNT;
        next_s    = ST_UPD_SUB;
      end
      ST_UPD_SUB: begin
        y_nxt_s   = y_r - XW'(s_r);
        s_nxt_s   = s_r - {{(SW-1){1'b0}}, 1'b1};
        cnt_nxt_s = cnt_r - 8'd1;
        if (cnt_r <= 8'd1) begin
          next_s = ST_OFF;
        end else begin
          next_s = ST_UPD_SUB;
        end
      end
      default: begin
        next_s = ST_OFF;
      end
    endcase
  end

  // State and data registers; reset aborts any mode immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_OFF;
      y_r      <= {XW{1'b0}};
      s_r      <= {SW{1'b0}};
      cnt_r    <= 8'd0;
      b_r      <= 1'b0;
      regime_r <= 2'd0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= next_s;
      y_r      <= y_nxt_s;
      s_r      <= s_nxt_s;
      cnt_r    <= cnt_nxt_s;
      b_r      <= b_nxt_s;
      regime_r <= regime_of(next_s);
      done_r   <= (state_r != ST_OFF) && (next_s == ST_OFF);
    end
  end

  assign bus.y      = y_r;
  assign bus.s      = s_r;
  assign bus.b      = b_r;
  assign bus.regime = regime_r;
  assign bus.active = (regime_r == 2'd0);
  assign bus.done   = done_r;

endmodule

// File: tb/tb_param_mode_engine.sv
// Directed bench for param_mode_engine: one instance with UPD_STEPS=1, one with UPD_STEPS=3.
module tb_param_mode_engine;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  param_mode_engine_if #(.XW(8), .SW(3)) ba ();
  param_mode_engine_if #(.XW(8), .SW(3)) bb ();

  param_mode_engine #(.XW(8), .SW(3), .UPD_STEPS(1)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  param_mode_engine #(.XW(8), .SW(3), .UPD_STEPS(3)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] cnt_s_exp [10];
    logic [7:0] cnt_y_exp [10];
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    ba.x = 8'd0; ba.on = 2'd0; ba.start = 1'b0;
    bb.x = 8'd0; bb.on = 2'd0; bb.start = 1'b0;
    cnt_s_exp = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
    cnt_y_exp = '{8'd26, 8'd26, 8'd26, 8'd26, 8'd26, 8'd26, 8'd27, 8'd27, 8'd27, 8'd27};

    // Reset state
    tick(); tick();
    check("rst_y", 32'(ba.y), 32'd0);
    check("rst_s", 32'(ba.s), 32'd0);
    check("rst_b", 32'(ba.b), 32'd0);
    check("rst_done", 32'(ba.done), 32'd0);
    check("rst_regime", 32'(ba.regime), 32'd0);
    check("rst_active", 32'(ba.active), 32'd1);
    rst = 1'b1;

    // Async reset in the middle of COUNT
    ba.on = 2'd2;
    tick();
    check("cnt0_regime", 32'(ba.regime), 32'd2);
    check("cnt0_active", 32'(ba.active), 32'd0);
    ba.on = 2'd0; ba.start = 1'b1;
    tick();
    check("cnt0_s", 32'(ba.s), 32'd7);
    check("cnt0_y", 32'(ba.y), 32'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_y", 32'(ba.y), 32'd0);
    check("arst_s", 32'(ba.s), 32'd0);
    check("arst_regime", 32'(ba.regime), 32'd0);
    check("arst_active", 32'(ba.active), 32'd1);
    tick();
    rst = 1'b1; ba.start = 1'b0;

    // UPDATE with x=5, s=0
    ba.on = 2'd3; ba.x = 8'd5;
    tick();
    check("u5_regime", 32'(ba.regime), 32'd3);
    check("u5_y_hold", 32'(ba.y), 32'd0);
    ba.on = 2'd0;
    tick();
    check("u5_load_y", 32'(ba.y), 32'd5);
    tick();
    check("u5_sub_y", 32'(ba.y), 32'd5);
    check("u5_sub_s", 32'(ba.s), 32'd7);
    check("u5_regime_off", 32'(ba.regime), 32'd0);
    check("u5_done", 32'(ba.done), 32'd1);
    tick();
    check("u5_done_clear", 32'(ba.done), 32'd0);

    // UPDATE with x=33, s=7
    ba.on = 2'd3; ba.x = 8'd33;
    tick();
    ba.on = 2'd0;
    tick();
    check("u33_load_y", 32'(ba.y), 32'd33);
    tick();
    check("u33_sub_y", 32'(ba.y), 32'd26);
    check("u33_sub_s", 32'(ba.s), 32'd6);
    check("u33_done", 32'(ba.done), 32'd1);

    // COUNT ten steps then exit
    ba.on = 2'd2;
    tick();
    check("cnt_regime", 32'(ba.regime), 32'd2);
    check("cnt_done_low", 32'(ba.done), 32'd0);
    ba.on = 2'd0; ba.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("cnt_s", 32'(ba.s), 32'(cnt_s_exp[i]));
      check("cnt_y", 32'(ba.y), 32'(cnt_y_exp[i]));
      check("cnt_b", 32'(ba.b), (i == 6) ? 32'd1 : 32'd0);
    end
    ba.start = 1'b0;
    tick();
    check("cnt_exit_regime", 32'(ba.regime), 32'd0);
    check("cnt_exit_done", 32'(ba.done), 32'd1);
    check("cnt_exit_s", 32'(ba.s), 32'd4);
    check("cnt_exit_y", 32'(ba.y), 32'd27);

    // ENUM: arm holds without start, then eight run edges
    ba.on = 2'd1;
    tick();
    check("enum_regime", 32'(ba.regime), 32'd1);
    ba.on = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arm_regime", 32'(ba.regime), 32'd1);
      check("arm_s", 32'(ba.s), 32'd4);
    end
    ba.start = 1'b1;
    tick();
    check("arm_go_s", 32'(ba.s), 32'd0);
    ba.start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      ba.on = (i % 2 == 1) ? 2'd3 : 2'd0;
      tick();
      check("run_s", 32'(ba.s), 32'(i));
      check("run_regime", 32'(ba.regime), 32'd1);
      check("run_b", 32'(ba.b), 32'd0);
    end
    ba.on = 2'd2;
    tick();
    ba.on = 2'd0;
    check("run_wrap_s", 32'(ba.s), 32'd0);
    check("run_wrap_y", 32'(ba.y), 32'd28);
    check("run_wrap_b", 32'(ba.b), 32'd1);
    check("run_wrap_regime", 32'(ba.regime), 32'd0);
    check("run_wrap_done", 32'(ba.done), 32'd1);
    tick();
    check("run_after_b", 32'(ba.b), 32'd0);
    check("run_after_regime", 32'(ba.regime), 32'd0);

    // UPD_STEPS=3 instance: bring s to 2 through COUNT, then UPDATE x=20
    bb.on = 2'd2;
    tick();
    bb.on = 2'd0; bb.start = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("u3_pre_s", 32'(bb.s), 32'd2);
    check("u3_pre_y", 32'(bb.y), 32'd1);
    bb.start = 1'b0;
    tick();
    bb.on = 2'd3; bb.x = 8'd20;
    tick();
    bb.on = 2'd0;
    tick();
    check("u3_load_y", 32'(bb.y), 32'd20);
    check("u3_load_s", 32'(bb.s), 32'd2);
    tick();
    check("u3_sub1_y", 32'(bb.y), 32'd18);
    check("u3_sub1_s", 32'(bb.s), 32'd1);
    check("u3_sub1_done", 32'(bb.done), 32'd0);
    tick();
    check("u3_sub2_y", 32'(bb.y), 32'd17);
    check("u3_sub2_s", 32'(bb.s), 32'd0);
    check("u3_sub2_regime", 32'(bb.regime), 32'd3);
    tick();
    check("u3_sub3_y", 32'(bb.y), 32'd17);
    check("u3_sub3_s", 32'(bb.s), 32'd7);
    check("u3_sub3_done", 32'(bb.done), 32'd1);
    check("u3_sub3_regime", 32'(bb.regime), 32'd0);
    tick();
    check("u3_done_clear", 32'(bb.done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_mode_engine.md
PARAM_MODE_ENGINE -- requirements
Module: param_mode_engine

Interface
REQ-001 The block SHALL have parameter XW, default 8, meaning data width of x and y (XW >= 2).
REQ-002 The block SHALL have parameter SW, default 3, meaning width of step counter s (1 <= SW <= XW).
REQ-003 The block SHALL have parameter UPD_STEPS, default 1, meaning number of subtract cycles in UPDATE mode (1..255).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port x, input, XW bits, load operand for UPDATE.
REQ-007 The block SHALL have port on, input, 2 bits, mode command: 0 none, 1 ENUM, 2 COUNT, 3 UPDATE.
REQ-008 The block SHALL have port start, input, 1 bit, run/continue qualifier for ENUM and COUNT.
REQ-009 The block SHALL have port y, output, XW bits, registered result.
REQ-010 The block SHALL have port s, output, SW bits, registered step counter.
REQ-011 The block SHALL have port b, output, 1 bit, registered carry/borrow pulse from s wrap.
REQ-012 The block SHALL have port regime, output, 2 bits, current mode (0 OFF, 1 ENUM, 2 COUNT, 3 UPDATE).
REQ-013 The block SHALL have port active, output, 1 bit, high only in OFF (command accepted).
REQ-014 The block SHALL have port done, output, 1 bit, one-cycle pulse on return to OFF from any mode.

Function
REQ-015 The FSM SHALL have states OFF, ENUM_ARM, ENUM_RUN, COUNT, UPD_LOAD, UPD_SUB; regime SHALL be 1 in ENUM_*, 2 in COUNT, 3 in UPD_*, 0 in OFF.
REQ-016 In OFF, an edge with on=1/2/3 SHALL move to ENUM_ARM/COUNT/UPD_LOAD respectively, changing no data register; on=0 SHALL stay OFF.
REQ-017 The on input SHALL be ignored in every state except OFF.
REQ-018 UPD_LOAD: next edge SHALL set y <= x and a sub-count to UPD_STEPS, then go to UPD_SUB.
REQ-019 UPD_SUB: each edge SHALL set y <= (y - zero-extended s) mod 2^XW and s <= (s - 1) mod 2^SW simultaneously, using pre-edge s; after UPD_STEPS such edges, that last edge SHALL go to OFF.
REQ-020 COUNT: edge with start=0 SHALL go to OFF with y, s unchanged; edge with start=1 SHALL set s <= (s - 1) mod 2^SW, and if pre-edge s = 0 also y <= (y + 1) mod 2^XW and b <= 1.
REQ-021 ENUM_ARM: edge with start=1 SHALL set s <= 0 and go to ENUM_RUN; start=0 SHALL stay in ENUM_ARM.
REQ-022 ENUM_RUN: each edge, start ignored, SHALL set s <= s + 1; on edge where pre-edge s = 2^SW-1, s SHALL wrap to 0, y <= (y + 1) mod 2^XW, b <= 1, and state SHALL go to OFF (exactly 2^SW run edges).
REQ-023 b SHALL be 0 on every edge not specified in REQ-020/022 (single-cycle pulse).
REQ-024 done SHALL be 1 for exactly the cycle following an edge that enters OFF from a non-OFF state, else 0.
REQ-025 active SHALL be combinationally (regime == 0).
REQ-026 y and s SHALL retain value across OFF and across mode changes.

Reset
REQ-027 rst=0 SHALL immediately, without clock, force state OFF, y=0, s=0, b=0, done=0, regime=0, active=1, aborting any mode mid-operation.
REQ-028 On rst release, first edge SHALL be evaluated as OFF.

Verification (defaults XW=8, SW=3, UPD_STEPS=1)
REQ-029 Reset pulse mid-COUNT -> y=0, s=0, regime=0, active=1 before next clk edge.
REQ-030 From reset, on=3 x=5 one edge, then on=0 -> regime=3, y=5, then y=5 s=7, OFF, done=1 one cycle.
REQ-031 Then on=3 x=33 -> y=33, then y=26 s=6, OFF.
REQ-032 Then on=2 one edge, start=1 ten edges -> s wraps 0->7 on 7th edge with y=27, b=1 one cycle; final s=4 y=27; start=0 edge -> OFF, done=1.
REQ-033 on=1 with start=0 three edges -> stays ENUM_ARM, s unchanged; start=1 edge -> s=0; 8 more edges -> s=0, y=y+1, b=1, OFF; on pulses during run ignored.
REQ-034 UPD_STEPS=3, x=20, s=2 -> y: 20, 18, 17, 17; s: 2, 1, 0, 7; done after third subtract.
